// File: rtl/decode_issue_if.sv
// Handshake and decoded-instruction bus between fetch, decode_issue and execute.
// The slave modport is the view taken by decode_issue; master is the
// environment (fetch + execute + writeback) side.
interface decode_issue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // Fetch side
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   in_pc;
    logic              flush;

    // Execute side
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [XLEN-1:0]   out_pc;
    logic              writes_rd;
    logic              illegal;

    // Writeback side
    logic              wb_en;
    logic [4:0]        wb_addr;

    modport slave (
        input  in_valid, instr, in_pc, flush, out_ready, wb_en, wb_addr,
        output in_ready, out_valid, ra1, ra2, rd, imm, opcode, funct3,
               funct7_5, out_pc, writes_rd, illegal
    );

    modport master (
        output in_valid, instr, in_pc, flush, out_ready, wb_en, wb_addr,
        input  in_ready, out_valid, ra1, ra2, rd, imm, opcode, funct3,
               funct7_5, out_pc, writes_rd, illegal
    );
endinterface

// File: rtl/decode_issue.sv
// RV32I single-stage decode/issue register with a 32-entry busy scoreboard.
// An instruction is captured in one holding register, decoded, and offered to
// execute only when none of its source or destination registers has a write
// still pending.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to flag opcodes outside the
// RV32I base set as illegal (they still issue so execute can trap). Without
// it, illegal is tied 0 and unknown opcodes decode as a NOP.
module decode_issue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_issue_if.slave bus
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_FENCE  = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    // Decode of the incoming instruction
    logic [XLEN-1:0] instr;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_wtype;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_ra1;
    logic [4:0]      dec_ra2;
    logic [4:0]      dec_rd;
    logic            dec_writes_rd;

    // Holding register
    logic            held_valid_q;
    logic [4:0]      ra1_q;
    logic [4:0]      ra2_q;
    logic [4:0]      rd_q;
    logic            writes_rd_q;
    logic            illegal_q;
    logic [XLEN-1:0] imm_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic            funct7_5_q;
    logic [XLEN-1:0] pc_q;

    // Scoreboard and handshake
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic            hazard;
    logic            out_valid;
    logic            in_ready;
    logic            issue;
    logic            capture;

    assign instr = bus.instr;

    // Classify the opcode: operand usage, rd write and immediate format.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves a value held, which would infer a latch.
        dec_uses_rs1 = 1'b0;
        dec_uses_rs2 = 1'b0;
        dec_wtype    = 1'b0;
        dec_illegal  = 1'b0;
        dec_imm      = '0;
        case (instr[6:0])
            OPC_OP: begin
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
                dec_wtype    = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_uses_rs1 = 1'b1;
                dec_wtype    = 1'b1;
                dec_imm      = XLEN'($signed(instr[31:20]));
            end
            OPC_STORE: begin
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
                dec_imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
                dec_imm      = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_wtype = 1'b1;
                dec_imm   = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                dec_wtype = 1'b1;
                dec_imm   = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                           instr[30:21], 1'b0}));
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Recognised but neither reads nor writes the integer file here.
                dec_imm = XLEN'($signed(instr[31:20]));
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
`else
                dec_illegal = 1'b0;
`endif
            end
        endcase
    end

    // Unused read ports and non-writing instructions present index 0.
    assign dec_ra1       = dec_uses_rs1 ? instr[19:15] : 5'd0;
    assign dec_ra2       = dec_uses_rs2 ? instr[24:20] : 5'd0;
    assign dec_writes_rd = dec_wtype && (instr[11:7] != 5'd0);
    assign dec_rd        = dec_writes_rd ? instr[11:7] : 5'd0;

    // Because unused ports are already 0 and busy[0] never sets, the usage
    // flags are folded into the indices.
    assign hazard    = busy_q[ra1_q] | busy_q[ra2_q] | (writes_rd_q & busy_q[rd_q]);
    assign out_valid = held_valid_q & ~hazard;
    assign issue     = out_valid & bus.out_ready;
    assign in_ready  = ~bus.flush & (~held_valid_q | issue);
    assign capture   = bus.in_valid & in_ready;

    // Holding register: capture on accept, drop on issue or flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            rd_q         <= '0;
            writes_rd_q  <= 1'b0;
            illegal_q    <= 1'b0;
            imm_q        <= '0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            funct7_5_q   <= 1'b0;
            pc_q         <= '0;
        end else if (bus.flush) begin
            held_valid_q <= 1'b0;
        end else if (capture) begin
            held_valid_q <= 1'b1;
            ra1_q        <= dec_ra1;
            ra2_q        <= dec_ra2;
            rd_q         <= dec_rd;
            writes_rd_q  <= dec_writes_rd;
            illegal_q    <= dec_illegal;
            imm_q        <= dec_imm;
            opcode_q     <= instr[6:0];
            funct3_q     <= instr[14:12];
            funct7_5_q   <= instr[30];
            pc_q         <= bus.in_pc;
        end else if (issue) begin
            held_valid_q <= 1'b0;
        end
    end

    // Scoreboard update: writeback clears, issue sets, and set wins on a tie.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (issue && writes_rd_q) begin
            busy_d[rd_q] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is 32 flops, not a RAM; it must clear on reset
        // because a stale busy bit would stall the pipeline forever.
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.ra1       = ADDR_W'(ra1_q);
    assign bus.ra2       = ADDR_W'(ra2_q);
    assign bus.rd        = ADDR_W'(rd_q);
    assign bus.imm       = imm_q;
    assign bus.opcode    = opcode_q;
    assign bus.funct3    = funct3_q;
    assign bus.funct7_5  = funct7_5_q;
    assign bus.out_pc    = pc_q;
    assign bus.writes_rd = writes_rd_q;
    assign bus.illegal   = illegal_q;

endmodule
